// File: rtl/calc_key_sequencer.sv
`default_nettype none
// ============================================================================
// calc_key_sequencer
// Keypad calculator control: scan-code filtering, operand entry, BCD ALU handshake.
// Revision: 1.0
// ============================================================================
module calc_key_sequencer #(
   parameter int TIMEOUT = 1024,
   parameter int NDIG    = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [7:0]          code_i,
   input  logic                code_valid_i,
   output logic                alu_start_o,
   output logic                alu_sub_o,
   output logic [4*NDIG-1:0]   alu_a_o,
   output logic                alu_a_neg_o,
   output logic [4*NDIG-1:0]   alu_b_o,
   input  logic                alu_done_i,
   input  logic [4*NDIG-1:0]   alu_res_i,
   input  logic                alu_neg_i,
   input  logic                alu_ovf_i,
   output logic [4*NDIG-1:0]   disp_bcd_o,
   output logic                disp_neg_o,
   output logic                disp_err_o
);

   localparam int W  = 4*NDIG;
   localparam int CW = $clog2(NDIG+1);
   localparam int TW = $clog2(TIMEOUT+1);

   localparam logic [7:0]    c_code_brk = 8'hF0;
   localparam logic [7:0]    c_code_ext = 8'hE0;
   localparam logic [CW-1:0] c_ndig     = CW'(NDIG);
   localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT-1);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_OP      = 3'd1,
      S_ENTER_B = 3'd2,
      S_CALC    = 3'd3,
      S_SHOW    = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic            r_a_neg;
   logic [CW-1:0]   r_cnt;
   logic            r_brk;
   logic            r_op;
   logic            r_sub;
   logic            r_chain;
   logic            r_start;
   logic [TW-1:0]   r_tmo;

   logic            w_key;
   logic            w_is_digit;
   logic            w_is_op;
   logic            w_op_sub;
   logic            w_is_eq;
   logic            w_is_esc;
   logic [3:0]      w_digit;
   logic            w_dig;
   logic            w_op;
   logic            w_eq;
   logic            w_esc;

   always_comb begin
      w_is_digit = 1'b0;
      w_is_op    = 1'b0;
      w_op_sub   = 1'b0;
      w_is_eq    = 1'b0;
      w_is_esc   = 1'b0;
      w_digit    = 4'd0;
      case (code_i)
         8'h45: begin w_is_digit = 1'b1; w_digit = 4'd0; end
         8'h16: begin w_is_digit = 1'b1; w_digit = 4'd1; end
         8'h1E: begin w_is_digit = 1'b1; w_digit = 4'd2; end
         8'h26: begin w_is_digit = 1'b1; w_digit = 4'd3; end
         8'h25: begin w_is_digit = 1'b1; w_digit = 4'd4; end
         8'h2E: begin w_is_digit = 1'b1; w_digit = 4'd5; end
         8'h36: begin w_is_digit = 1'b1; w_digit = 4'd6; end
         8'h3D: begin w_is_digit = 1'b1; w_digit = 4'd7; end
         8'h3E: begin w_is_digit = 1'b1; w_digit = 4'd8; end
         8'h46: begin w_is_digit = 1'b1; w_digit = 4'd9; end
         8'h79: begin w_is_op = 1'b1; w_op_sub = 1'b0; end
         8'h7B: begin w_is_op = 1'b1; w_op_sub = 1'b1; end
         8'h55, 8'h5A: w_is_eq = 1'b1;
         8'h76: w_is_esc = 1'b1;
         default: ;
      endcase
   end

   // A code is a usable key only when it is neither a prefix nor the code after F0.
   assign w_key = code_valid_i && !r_brk && (code_i != c_code_ext) && (code_i != c_code_brk);
   assign w_dig = w_key && w_is_digit;
   assign w_op  = w_key && w_is_op;
   assign w_eq  = w_key && w_is_eq;
   assign w_esc = w_key && w_is_esc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_ENTER_A;
         r_a     <= '0;
         r_b     <= '0;
         r_a_neg <= 1'b0;
         r_cnt   <= '0;
         r_brk   <= 1'b0;
         r_op    <= 1'b0;
         r_sub   <= 1'b0;
         r_chain <= 1'b0;
         r_start <= 1'b0;
         r_tmo   <= '0;
      end else begin
         r_start <= 1'b0;
         if (code_valid_i && (code_i != c_code_ext))
            r_brk <= (code_i == c_code_brk) && !r_brk;

         if (w_esc) begin
            r_state <= S_ENTER_A;
            r_a     <= '0;
            r_b     <= '0;
            r_a_neg <= 1'b0;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_sub   <= 1'b0;
            r_chain <= 1'b0;
            r_tmo   <= '0;
         end else begin
            case (r_state)
               S_ENTER_A: begin
                  if (w_dig) begin
                     if (r_cnt < c_ndig) begin
                        r_a   <= (r_a << 4) | W'(w_digit);
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end else if (w_op) begin
                     r_op    <= w_op_sub;
                     r_state <= S_OP;
                  end
               end
               S_OP: begin
                  if (w_op) begin
                     r_op <= w_op_sub;
                  end else if (w_dig) begin
                     r_b     <= W'(w_digit);
                     r_cnt   <= CW'(1);
                     r_state <= S_ENTER_B;
                  end
               end
               S_ENTER_B: begin
                  if (w_dig) begin
                     if (r_cnt < c_ndig) begin
                        r_b   <= (r_b << 4) | W'(w_digit);
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end else if (w_eq || w_op) begin
                     // r_sub carries the operator being executed; r_op becomes the pending one.
                     r_sub   <= r_op;
                     r_chain <= w_op;
                     if (w_op)
                        r_op <= w_op_sub;
                     r_start <= 1'b1;
                     r_tmo   <= '0;
                     r_state <= S_CALC;
                  end
               end
               S_CALC: begin
                  if (alu_done_i) begin
                     if (alu_ovf_i) begin
                        r_state <= S_ERR;
                     end else begin
                        r_a     <= alu_res_i;
                        r_a_neg <= alu_neg_i;
                        r_state <= r_chain ? S_OP : S_SHOW;
                     end
                  end else if (r_tmo == c_tmo_last) begin
                     r_state <= S_ERR;
                  end else begin
                     r_tmo <= r_tmo + 1'b1;
                  end
               end
               S_SHOW: begin
                  if (w_dig) begin
                     r_a     <= W'(w_digit);
                     r_a_neg <= 1'b0;
                     r_cnt   <= CW'(1);
                     r_state <= S_ENTER_A;
                  end else if (w_op) begin
                     r_op    <= w_op_sub;
                     r_state <= S_OP;
                  end
               end
               S_ERR: ;
               default: r_state <= S_ENTER_A;
            endcase
         end
      end
   end

   assign alu_start_o = r_start;
   assign alu_sub_o   = r_sub;
   assign alu_a_o     = r_a;
   assign alu_a_neg_o = r_a_neg;
   assign alu_b_o     = r_b;

   // B is untouched during CALC, so showing B there holds the last displayed value.
   always_comb begin
      disp_bcd_o = r_a;
      disp_neg_o = r_a_neg;
      disp_err_o = 1'b0;
      case (r_state)
         S_ENTER_B, S_CALC: begin
            disp_bcd_o = r_b;
            disp_neg_o = 1'b0;
         end
         S_ERR: begin
            disp_bcd_o = '0;
            disp_neg_o = 1'b0;
            disp_err_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire
